// File: rtl/spi_flash_pkg.sv
// Shared constants, state type and helpers for the single-bit SPI flash read controller.
package spi_flash_pkg;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned TOTAL_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP,
    GAP
  } state_e;

  // Bytes arrive b0 first and land MSB-first in the receive register; the word is little-endian.
  function automatic logic [DATA_BITS-1:0] byte_swap32(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK decode from the bit-period divider count: CLK_DIV cycles low, then CLK_DIV cycles high.
module spi_sck_gen
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned DIV_W   = $clog2(CLK_DIV) + 1
) (
  input  logic [DIV_W-1:0] div_cnt,
  input  logic             en,
  output logic             sck,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  localparam logic [DIV_W-1:0] HALF    = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] LOW_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LAST    = DIV_W'(2 * CLK_DIV - 1);

  // Strobes mark the clock edge at which sck changes: rise closes the last low cycle,
  // fall closes the last high cycle of the bit period.
  assign sck        = en && (div_cnt >= HALF);
  assign rise_pulse = en && (div_cnt == LOW_END);
  assign fall_pulse = en && (div_cnt == LAST);

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// SPI mode-0 READ (0x03) controller: fetches one little-endian 32-bit word per request.
module spi_flash_read_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  spi_sck,
  output logic                  spi_cs,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_EXIT   = GAP_W'(CS_GAP - 1);
  localparam logic [6:0]       LAST_BIT   = 7'(TOTAL_BITS - 1);
  localparam logic [6:0]       FIRST_DATA = 7'(CMD_BITS + ADDR_BITS);

  state_e                 state, state_next;
  logic [DIV_W-1:0]       div_cnt;
  logic [6:0]             bit_cnt;
  logic [31:0]            tx_sr;
  logic [DATA_BITS-1:0]   rx_sr;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   shifting;
  logic                   sck_rise;
  logic                   sck_fall;

  assign shifting = (state == SHIFT);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_sck_gen (
    .div_cnt    (div_cnt),
    .en         (shifting),
    .sck        (spi_sck),
    .rise_pulse (sck_rise),
    .fall_pulse (sck_fall)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    spi_cs     = 1'b1;
    spi_mosi   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_next = SHIFT;
      end
      SHIFT: begin
        spi_cs   = 1'b0;
        spi_mosi = tx_sr[31];
        if (sck_fall && bit_cnt == LAST_BIT) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = GAP;
      end
      GAP: begin
        if (gap_cnt >= GAP_EXIT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      gap_cnt   <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tx_sr   <= {CMD_READ, req_addr};
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          div_cnt <= sck_fall ? '0 : div_cnt + DIV_W'(1);
          if (sck_rise && bit_cnt >= FIRST_DATA) rx_sr <= {rx_sr[DATA_BITS-2:0], spi_miso};
          if (sck_fall) begin
            tx_sr   <= {tx_sr[30:0], 1'b0};
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == LAST_BIT) begin
              resp_data <= byte_swap32(rx_sr);
              gap_cnt   <= '0;
            end
          end
        end
        // gap_cnt counts from the cycle cs rose, so RESP time counts toward the gap
        RESP, GAP: begin
          if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: CLK_DIV=1 and CLK_DIV=3 instances against a behavioural flash image.
module tb_spi_flash_read_ctrl;

  localparam int unsigned CS_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [23:0] req_addr  [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_data [2];
  logic        sck       [2];
  logic        cs        [2];
  logic        mosi      [2];
  logic [31:0] fin_w     [2];

  logic [7:0] image [logic [23:0]];

  function automatic logic [7:0] img(input logic [23:0] a);
    logic [7:0] r;
    if (image.exists(a)) return image[a];
    r = (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    return {img(a + 24'd3), img(a + 24'd2), img(a + 24'd1), img(a)};
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned DIV = (g == 0) ? 1 : 3;
    logic        miso_r = 1'b0;
    int          fcnt = 0;
    logic [31:0] fin = '0;
    logic [7:0]  fb;
    int          d;

    spi_flash_read_ctrl #(
      .CLK_DIV    (DIV),
      .CS_GAP     (CS_GAP),
      .ADDR_WIDTH (24)
    ) dut (
      .clock      (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .spi_sck    (sck[g]),
      .spi_cs     (cs[g]),
      .spi_mosi   (mosi[g]),
      .spi_miso   (miso_r)
    );

    // Mode-0 flash: capture command+address on rising sck, drive data after falling sck
    always @(negedge cs[g] or posedge sck[g]) begin
      if (!sck[g]) fcnt = 0;
      else if (!cs[g]) begin
        if (fcnt < 32) fin = {fin[30:0], mosi[g]};
        fcnt++;
      end
    end

    always @(negedge sck[g]) begin
      if (!cs[g] && fcnt >= 32 && fcnt < 64) begin
        d      = fcnt - 32;
        fb     = img(fin[23:0] + 24'(d / 8));
        miso_r = fb[7 - (d % 8)];
      end
    end

    assign fin_w[g] = fin;
  end

  int          n_checks, n_errs, cyc;
  int          hs_cyc[2], rise_cyc[2], hand_cyc[2];
  int          lowcnt[2], highcnt[2], hrun[2], rmin[2], rmax[2];
  int          mode[2];
  logic        prev_cs[2], prev_valid[2], pend_ready[2], done_tx[2];
  logic [31:0] last_data[2], last_resp[2];
  logic [31:0] exp_q[2][$];
  logic [31:0] frame_q[2][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor(input int k);
    int dv;
    int want;
    dv = div_of(k);
    if (sck[k]) hrun[k]++;
    else if (hrun[k] != 0) begin
      if (hrun[k] < rmin[k]) rmin[k] = hrun[k];
      if (hrun[k] > rmax[k]) rmax[k] = hrun[k];
      hrun[k] = 0;
    end
    if (!cs[k]) begin
      if (prev_cs[k]) begin
        if (done_tx[k]) check("cs_gap_min", 32'(highcnt[k] >= CS_GAP), 32'd1);
        lowcnt[k] = 0;
        rmin[k]   = 1000;
        rmax[k]   = 0;
      end
      lowcnt[k]++;
    end else begin
      if (!prev_cs[k]) highcnt[k] = 1;
      else             highcnt[k]++;
    end
    if (resp_valid[k] && !prev_valid[k]) begin
      check("latency", 32'(cyc - hs_cyc[k]), 32'(1 + 128 * dv));
      check("cs_low_len", 32'(lowcnt[k]), 32'(128 * dv));
      check("sck_high_min", 32'(rmin[k]), 32'(dv));
      check("sck_high_max", 32'(rmax[k]), 32'(dv));
      if (frame_q[k].size() != 0) check("mosi_frame", fin_w[k], frame_q[k].pop_front());
      else check("unexpected_resp", 32'(frame_q[k].size()), 32'd1);
      rise_cyc[k]  = cyc;
      last_data[k] = resp_data[k];
    end else if (resp_valid[k]) begin
      check("resp_hold", resp_data[k], last_data[k]);
    end
    if (resp_valid[k] && resp_ready[k]) begin
      last_resp[k]  = resp_data[k];
      hand_cyc[k]   = cyc;
      pend_ready[k] = 1'b1;
      done_tx[k]    = 1'b1;
      if (exp_q[k].size() != 0) check("resp_data", resp_data[k], exp_q[k].pop_front());
      else check("unexpected_hs", 32'(exp_q[k].size()), 32'd1);
    end
    if (pend_ready[k] && req_ready[k]) begin
      want = (rise_cyc[k] + CS_GAP > hand_cyc[k] + 2) ? rise_cyc[k] + CS_GAP : hand_cyc[k] + 2;
      check("ready_rise", 32'(cyc), 32'(want));
      pend_ready[k] = 1'b0;
    end
    prev_cs[k]    = cs[k];
    prev_valid[k] = resp_valid[k];
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      case (mode[k])
        0:       resp_ready[k] = 1'b0;
        1:       resp_ready[k] = 1'b1;
        default: resp_ready[k] = ($urandom_range(0, 2) != 0);
      endcase
      monitor(k);
    end
  endtask

  task automatic issue(input int k, input logic [23:0] a);
    int n = 0;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    while (!req_ready[k] && n < 5000) begin
      step();
      n++;
    end
    if (!req_ready[k]) begin
      check("req_timeout", 32'(req_ready[k]), 32'd1);
      return;
    end
    hs_cyc[k] = cyc;
    exp_q[k].push_back(ref_word(a));
    frame_q[k].push_back({8'h03, a});
    step();
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while ((exp_q[k].size() != 0 || pend_ready[k]) && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) check("done_timeout", 32'(exp_q[k].size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_req_ready", 32'(req_ready[k]), 32'd0);
    check("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
    check("rst_resp_data", resp_data[k], 32'd0);
    check("rst_sck", 32'(sck[k]), 32'd0);
    check("rst_cs", 32'(cs[k]), 32'd1);
    check("rst_mosi", 32'(mosi[k]), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    logic [23:0] a;
    n_checks = 0;
    n_errs   = 0;
    cyc      = 0;
    reset    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_addr[i]   = '0;
      resp_ready[i] = 1'b1;
      mode[i]       = 1;
      hs_cyc[i]     = 0;
      rise_cyc[i]   = 0;
      hand_cyc[i]   = 0;
      lowcnt[i]     = 0;
      highcnt[i]    = 0;
      hrun[i]       = 0;
      rmin[i]       = 1000;
      rmax[i]       = 0;
      prev_cs[i]    = 1'b1;
      prev_valid[i] = 1'b0;
      pend_ready[i] = 1'b0;
      done_tx[i]    = 1'b0;
      last_data[i]  = '0;
      last_resp[i]  = '0;
    end
    image[24'h000010] = 8'h13;
    image[24'h000011] = 8'h05;
    image[24'h000012] = 8'h00;
    image[24'h000013] = 8'h00;
    image[24'h000014] = 8'hAA;

    repeat (3) step();
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    step();
    check("ready_after_rst", 32'(req_ready[0]), 32'd1);

    // basic read, CLK_DIV=1
    issue(0, 24'h000010);
    req_valid[0] = 1'b0;
    wait_done(0);
    check("basic_word", last_resp[0], 32'h00000513);

    // same read, CLK_DIV=3
    issue(1, 24'h000010);
    req_valid[1] = 1'b0;
    wait_done(1);
    check("div3_word", last_resp[1], 32'h00000513);

    // backpressure for 50 cycles
    mode[0] = 0;
    issue(0, 24'h000020);
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 1000) begin
      step();
      n++;
    end
    for (int i = 0; i < 50; i++) begin
      check("bp_valid", 32'(resp_valid[0]), 32'd1);
      check("bp_ready", 32'(req_ready[0]), 32'd0);
      check("bp_cs", 32'(cs[0]), 32'd1);
      step();
    end
    mode[0] = 1;
    wait_done(0);

    // back-to-back with req_valid held high
    issue(0, 24'h000000);
    issue(0, 24'h000004);
    req_valid[0] = 1'b0;
    wait_done(0);

    // reset during data bit 20
    issue(0, 24'h000010);
    req_valid[0] = 1'b0;
    while (cyc < hs_cyc[0] + 1 + 2 * 52 + 1) step();
    reset = 1'b1;
    step();
    check("abort_cs", 32'(cs[0]), 32'd1);
    check("abort_sck", 32'(sck[0]), 32'd0);
    check("abort_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_ready", 32'(req_ready[0]), 32'd0);
    exp_q[0].delete();
    frame_q[0].delete();
    pend_ready[0] = 1'b0;
    done_tx[0]    = 1'b0;
    reset = 1'b0;
    step();
    issue(0, 24'h000010);
    req_valid[0] = 1'b0;
    wait_done(0);
    check("after_abort_word", last_resp[0], 32'h00000513);

    // unaligned and top-of-range addresses
    issue(0, 24'h000011);
    req_valid[0] = 1'b0;
    wait_done(0);
    check("unaligned_word", last_resp[0], 32'hAA000005);
    issue(0, 24'hFFFFFE);
    req_valid[0] = 1'b0;
    wait_done(0);

    // randomized reads with random consumer backpressure
    for (int i = 0; i < 16; i++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
      else                           a = 24'($urandom);
      mode[k] = 2;
      issue(k, a);
      req_valid[k] = 1'b0;
      wait_done(k);
      mode[k] = 1;
    end

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
Single-bit SPI (mode 0) read controller that fetches 32-bit words from external flash using the standard READ command (0x03).
- Sits between the SoC boot/instruction-fetch port and the board QSPI pins: drives sck, cs, dq_0 (MOSI) and samples dq_1 (MISO).
- Matches the simulation flash model's single-bit read path, so boot firmware loads from the preloaded hex image.

Parameters:
- CLK_DIV, 1, system clock cycles per SCK half-period (≥1).
- CS_GAP, 4, minimum cycles cs stays high between transactions (≥1).
- ADDR_WIDTH, 24, flash byte-address width; fixed by command format.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  controller can accept a request.
- req_addr  in  24  flash byte address; unaligned addresses are allowed.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts data.
- resp_data  out  32  read word, little-endian.
- spi_sck  out  1  SPI clock; idles low.
- spi_cs  out  1  chip select, active-low; idles high.
- spi_mosi  out  1  to flash dq_0.
- spi_miso  in  1  from flash dq_1.

Behaviour:
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after reset deasserts.
  - resp_valid=0, resp_data=0, spi_sck=0, spi_cs=1, spi_mosi=0.
- States: IDLE, SHIFT, RESP, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch the 32-bit frame {0x03, req_addr} and go to SHIFT.
  - On the next cycle, cs=0 and mosi=frame bit 31.
- SHIFT:
  - 64 bit periods: 8 command, 24 address, then 32 data (mosi=0 during data).
  - Each bit period is 2*CLK_DIV cycles: CLK_DIV cycles sck low, then CLK_DIV cycles sck high.
  - miso is sampled in the cycle sck goes 0→1.
  - mosi advances to the next bit in the cycle sck goes 1→0.
  - All fields are MSB first.
  - A 7-bit bit counter and a divider counter of width clog2(CLK_DIV)+1 run here.
- SHIFT exit: in the cycle the 64th high phase ends, sck=0, cs=1, resp_valid=1, and the state goes to RESP.
  - cs is low for exactly 128*CLK_DIV cycles.
  - resp_valid first asserts at cycle 1+128*CLK_DIV, counting the request handshake cycle as 0.
- Data assembly:
  - Received bytes b0..b3 in arrival order give resp_data={b3,b2,b1,b0}.
  - Within each byte, the first received bit is bit 7.
- RESP:
  - resp_valid and resp_data are held stable until resp_valid&&resp_ready.
  - On that handshake, resp_valid=0 on the next cycle and the state goes to GAP.
- GAP: cs held high for CS_GAP cycles, counted from the cycle cs rose, with at least 1 cycle in GAP. Then go to IDLE.
- req_ready=0 in every state except IDLE; requests while busy are not accepted.
- Address wrap: an address near the top (e.g. 0xFFFFFE) is sent unmodified; the flash handles wrap.
- Reset mid-transaction:
  - The next edge forces all outputs to their reset values; partial data is discarded.
  - sck never glitches high during reset.
- resp_ready held high in advance: the handshake completes in the first resp_valid cycle.

Decomposition:
- Package spi_flash_pkg:
  - CMD_READ=8'h03, CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32, TOTAL_BITS=64.
  - State enum state_e {IDLE, SHIFT, RESP, GAP}.
- Sub-module spi_sck_gen:
  - Inputs: divider counter, enable, CLK_DIV.
  - Outputs: sck, plus single-cycle rise_pulse and fall_pulse strobes.
  - The parent FSM uses these strobes for sampling and shifting.

Test Plan:
1. Basic read:
   - Flash model preloaded with bytes 0x13,0x05,0x00,0x00 at addr 0x000010.
   - Request addr 0x000010 → MOSI stream is 0x03,0x00,0x00,0x10; resp_data=0x00000513.
   - resp_valid at cycle 129 (CLK_DIV=1); cs low for exactly 128 cycles.
2. Timing with CLK_DIV=3:
   - Same read → sck high/low phases are 3 cycles each; cs low 384 cycles; same data.
3. Backpressure:
   - Hold resp_ready=0 for 50 cycles → resp_valid and data stable, req_ready=0, cs=1 throughout.
   - Release → handshake; req_ready rises CS_GAP cycles after cs rose (no earlier than after the handshake).
4. Back-to-back:
   - req_valid held high with addrs 0x000000 then 0x000004, resp_ready=1.
   - → two transactions separated by ≥CS_GAP cycles of cs high; responses in order match the image words.
5. Reset mid-transfer:
   - Assert reset during data bit 20 → next cycle cs=1, sck=0, resp_valid=0.
   - Subsequent read of 0x000010 returns 0x00000513 correctly.
6. Unaligned read:
   - Addr 0x000011 with bytes 0x05,0x00,0x00,0xAA at 0x11..0x14 → resp_data=0xAA000005.
